// File: rtl/lmem_layered_pipe_pkg.sv
// Shared LLR memory types, sizes and saturation/sign helpers for the layered decoder.
// Optional feature macro: LMEM_RDWR_FWD_EN (same-cycle write-to-read forwarding).
package lmem_layered_pipe_pkg;

   localparam int unsigned W         = 6;
   localparam int unsigned P         = 26;
   localparam int unsigned NB        = 16;
   localparam int unsigned KB        = 14;
   localparam int unsigned WT        = 2;
   localparam int unsigned LAYERS    = 2;
   localparam int unsigned ADDRDEPTH = 20;
   localparam int unsigned ADDRW     = 5;
   localparam int unsigned LAYERW    = 1;

   localparam int unsigned LANES = P * NB * WT;
   localparam int unsigned DW    = LANES * W;
   localparam int unsigned HDW   = P * KB;

   typedef logic [W-1:0]   llr_t;
   typedef logic [DW-1:0]  word_t;
   typedef logic [HDW-1:0] hd_t;

   localparam llr_t MAXVAL     = {1'b0, {(W-1){1'b1}}};
   localparam llr_t NEG_MAXVAL = ~MAXVAL + llr_t'(1);
   localparam llr_t LLR_MIN    = {1'b1, {(W-1){1'b0}}};

   // Kind of request travelling through the shared read pipeline
   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_RD   = 2'd1,
      TAG_HD   = 2'd2
   } tag_e;

   // Symmetric range: the lone most-negative code folds onto -MAXVAL
   function automatic llr_t sat_llr(input llr_t x);
      return (x == LLR_MIN) ? NEG_MAXVAL : x;
   endfunction

   function automatic logic llr_sign(input llr_t x);
      return x[W-1];
   endfunction

   // Systematic hard decisions: bit j is the sign of lane j*WT
   function automatic hd_t hd_extract(input word_t w);
      hd_t h;
      h = '0;
      for (int j = 0; j < int'(HDW); j++) begin
         h[j] = llr_sign(w[(j*WT)*W +: W]);
      end
      return h;
   endfunction

endpackage

// File: rtl/lmem_layered_pipe_if.sv
// Port bundle of the LLR memory: load, RCU write-back, layer read and hard-decision unload.
interface lmem_layered_pipe_if;
   import lmem_layered_pipe_pkg::*;

   logic              load_en;
   logic [ADDRW-1:0]  load_addr;
   word_t             load_data;

   logic              wr_en;
   logic [LAYERW-1:0] wr_layer;
   logic [ADDRW-1:0]  wr_addr;
   word_t             wr_data;

   logic              rd_en;
   logic [LAYERW-1:0] rd_layer;
   logic [ADDRW-1:0]  rd_addr;
   word_t             rd_data;
   logic              rd_valid;

   logic              unload_en;
   logic [ADDRW-1:0]  unload_addr;
   hd_t               hd_out;
   logic              hd_valid;

   logic              err;

   modport master (
      output load_en, load_addr, load_data,
      output wr_en, wr_layer, wr_addr, wr_data,
      output rd_en, rd_layer, rd_addr,
      output unload_en, unload_addr,
      input  rd_data, rd_valid, hd_out, hd_valid, err
   );

   modport slave (
      input  load_en, load_addr, load_data,
      input  wr_en, wr_layer, wr_addr, wr_data,
      input  rd_en, rd_layer, rd_addr,
      input  unload_en, unload_addr,
      output rd_data, rd_valid, hd_out, hd_valid, err
   );

endinterface

// File: rtl/lmem_layered_pipe_sat_lane.sv
// One-lane symmetric LLR saturator used on the shared write/load data path.
module lmem_layered_pipe_sat_lane
   import lmem_layered_pipe_pkg::*;
(
   input  llr_t llr_i,
   output llr_t llr_c
);

   assign llr_c = sat_llr(llr_i);

endmodule

// File: rtl/lmem_layered_pipe.sv
// Layered LLR memory: saturating load/write, 2-cycle pipelined read and hard-decision unload.
// Build option: define LMEM_RDWR_FWD_EN to forward same-cycle written data to the read port.
module lmem_layered_pipe
   import lmem_layered_pipe_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   lmem_layered_pipe_if.slave bus
);

   logic              load_addr_ok;
   logic              wr_addr_ok;
   logic              rd_addr_ok;
   logic              unload_addr_ok;
   logic              wr_layer_ok;
   logic              rd_layer_ok;

   logic              load_v;
   logic              wr_v;
   word_t             src_data;
   word_t             sat_data;
   logic [ADDRW-1:0]  wa;

   word_t             mem_q [LAYERS][ADDRDEPTH];

   logic [LAYERW-1:0] ra_layer;
   logic [ADDRW-1:0]  ra_addr;
   logic              ra_ok;
   tag_e              tag_d;
   word_t             s1_word_d;
   logic              err_d;

   tag_e              s1_tag_q;
   word_t             s1_word_q;
   word_t             rd_data_d,  rd_data_q;
   logic              rd_valid_d, rd_valid_q;
   hd_t               hd_d,       hd_q;
   logic              hd_valid_d, hd_valid_q;
   logic              err_q;

   assign load_addr_ok   = bus.load_addr   < ADDRW'(ADDRDEPTH);
   assign wr_addr_ok     = bus.wr_addr     < ADDRW'(ADDRDEPTH);
   assign rd_addr_ok     = bus.rd_addr     < ADDRW'(ADDRDEPTH);
   assign unload_addr_ok = bus.unload_addr < ADDRW'(ADDRDEPTH);

   // Layer range check only exists when the index can encode unused layers
   if (2**LAYERW > LAYERS) begin : g_layer_chk
      assign wr_layer_ok = bus.wr_layer < LAYERW'(LAYERS);
      assign rd_layer_ok = bus.rd_layer < LAYERW'(LAYERS);
   end else begin : g_layer_full
      assign wr_layer_ok = 1'b1;
      assign rd_layer_ok = 1'b1;
   end

   // Load has priority over RCU write-back and shares its saturator bank
   assign load_v   = bus.load_en & load_addr_ok;
   assign wr_v     = bus.wr_en & ~bus.load_en & wr_addr_ok & wr_layer_ok;
   assign src_data = bus.load_en ? bus.load_data : bus.wr_data;
   assign wa       = bus.load_en ? bus.load_addr : bus.wr_addr;

   for (genvar i = 0; i < int'(LANES); i++) begin : g_sat
      lmem_layered_pipe_sat_lane u_sat (
         .llr_i (src_data[i*W +: W]),
         .llr_c (sat_data[i*W +: W])
      );
   end

   // Storage is not reset; a write coinciding with reset is discarded
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int l = 0; l < int'(LAYERS); l++) begin
            if (load_v || (wr_v && (bus.wr_layer == LAYERW'(l)))) begin
               mem_q[l][wa] <= sat_data;
            end
         end
      end
   end

   // Read-port arbitration, stage-1 data selection and error detection
   always_comb begin
      tag_d     = TAG_NONE;
      ra_layer  = bus.rd_layer;
      ra_addr   = bus.rd_addr;
      ra_ok     = rd_addr_ok & rd_layer_ok;
      s1_word_d = '0;

      if (bus.rd_en) begin
         tag_d = TAG_RD;
      end else if (bus.unload_en) begin
         tag_d    = TAG_HD;
         ra_layer = LAYERW'(LAYERS - 1);
         ra_addr  = bus.unload_addr;
         ra_ok    = unload_addr_ok;
      end

      if ((tag_d != TAG_NONE) && ra_ok) begin
         s1_word_d = mem_q[ra_layer][ra_addr];
`ifdef LMEM_RDWR_FWD_EN
         if (load_v && (ra_addr == bus.load_addr)) begin
            s1_word_d = sat_data;
         end else if (wr_v && (ra_addr == bus.wr_addr) && (ra_layer == bus.wr_layer)) begin
            s1_word_d = sat_data;
         end
`endif
      end

      err_d = (bus.load_en & bus.wr_en)
            | (bus.load_en & ~load_addr_ok)
            | (bus.wr_en & ~bus.load_en & ~(wr_addr_ok & wr_layer_ok))
            | (bus.rd_en & bus.unload_en)
            | ((tag_d != TAG_NONE) & ~ra_ok);
   end

   // Stage 2: route the stage-1 word to the read or hard-decision output
   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      hd_d       = hd_q;
      hd_valid_d = 1'b0;
      case (s1_tag_q)
         TAG_RD: begin
            rd_data_d  = s1_word_q;
            rd_valid_d = 1'b1;
         end
         TAG_HD: begin
            hd_d       = hd_extract(s1_word_q);
            hd_valid_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_tag_q   <= TAG_NONE;
         s1_word_q  <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         hd_q       <= '0;
         hd_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         s1_tag_q   <= tag_d;
         s1_word_q  <= s1_word_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         hd_q       <= hd_d;
         hd_valid_q <= hd_valid_d;
         err_q      <= err_d;
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.hd_out   = hd_q;
   assign bus.hd_valid = hd_valid_q;
   assign bus.err      = err_q;

endmodule
